// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants, slot bundle and helpers.
// Optional misalign checking is selected with `IF_MISALIGN_CHK_EN.
package if_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } slot_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// In-order fetch slot queue: allocate at grant, fill on response,
// pop toward decode. Pointers carry a wrap bit so no per-slot flags.
module if_fetch_queue
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_addr_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [CW-1:0]   count_o,
  output logic [CW-1:0]   pending_o,
  output logic            head_valid_o,
  output logic [XLEN-1:0] head_addr_o,
  output logic [XLEN-1:0] head_data_o
);

  localparam logic [PW:0] ONE = 1;

  logic [PW:0] head_q, head_d;
  logic [PW:0] tail_q, tail_d;
  logic [PW:0] fill_q, fill_d;
  slot_t       slot_q [DEPTH];
  slot_t       slot_d [DEPTH];

  logic [PW-1:0] head_idx;
  logic [PW-1:0] tail_idx;
  logic [PW-1:0] fill_idx;

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign fill_idx = fill_q[PW-1:0];

  // [head, fill) are filled words, [fill, tail) await data
  assign count_o      = tail_q - head_q;
  assign pending_o    = tail_q - fill_q;
  assign head_valid_o = (fill_q != head_q);
  assign head_addr_o  = slot_q[head_idx].addr;
  assign head_data_o  = slot_q[head_idx].data;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    slot_d = slot_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
    end else begin
      if (alloc_i) begin
        slot_d[tail_idx].addr = alloc_addr_i;
        tail_d = tail_q + ONE;
      end
      if (fill_i && (pending_o != '0)) begin
        slot_d[fill_idx].data = fill_data_i;
        fill_d = fill_q + ONE;
      end
      if (pop_i && head_valid_o) begin
        head_d = head_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC, imem issue, redirect discard, decode handoff.
// `IF_MISALIGN_CHK_EN adds fetch_err_o for misaligned redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
`ifdef IF_MISALIGN_CHK_EN
  output logic            fetch_err_o,
`endif
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   disc_sum;
  logic [XLEN-1:0] jump_tgt;
  logic            issue_block;

  logic [CW-1:0]   count;
  logic [CW-1:0]   pending;
  logic            head_valid;
  logic [XLEN-1:0] head_addr;
  logic [XLEN-1:0] head_data;

  logic alloc;
  logic fill;
  logic pop;

`ifdef IF_MISALIGN_CHK_EN
  logic err_q, err_d;

  assign jump_tgt    = jump_addr_i;
  assign issue_block = err_q;
  assign fetch_err_o = err_q;

  always_comb begin
    err_d = err_q;
    if (jump_en_i) begin
      err_d = (jump_tgt[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign jump_tgt    = word_align(jump_addr_i);
  assign issue_block = 1'b0;
`endif

  assign imem_req_o = !rst && !jump_en_i && !issue_block
                   && (count < FULL);
  assign imem_addr_o = word_align(pc_q);

  assign alloc = imem_req_o && imem_gnt_i;
  // words in a redirect cycle always belong to the old stream
  assign fill  = imem_rvalid_i && !jump_en_i
              && (discard_q == '0);

  assign inst_valid_o = head_valid && !jump_en_i && !rst;
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = inst_valid_o ? head_data : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? head_addr : ZERO_WORD;

  always_comb begin
    pc_d = pc_q;
    if (jump_en_i) begin
      pc_d = jump_tgt;
    end else if (alloc) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_comb begin
    discard_d = discard_q;
    disc_sum  = discard_q + pending;
    if (jump_en_i) begin
      discard_d = (imem_rvalid_i && (disc_sum != '0))
                ? disc_sum - ONE : disc_sum;
    end else if (imem_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  if_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (alloc),
    .alloc_addr_i (imem_addr_o),
    .fill_i       (fill),
    .fill_data_i  (imem_rdata_i),
    .pop_i        (pop),
    .flush_i      (jump_en_i),
    .count_o      (count),
    .pending_o    (pending),
    .head_valid_o (head_valid),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch with a queued imem responder.
// Build with `IF_MISALIGN_CHK_EN to cover fetch_err_o.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_err_o;
`endif

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC (32'h0),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
`ifdef IF_MISALIGN_CHK_EN
    .fetch_err_o   (fetch_err_o),
`endif
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mq[$];
  logic        gnt_en;
  logic        rsp_en;
  int          compared   = 0;
  int          mismatched = 0;
  int          pops       = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start);
    logic [31:0] a;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      a = start + 32'(4 * i);
      sb.push_back('{a, mem_word(a)});
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pops(input string name,
                           input int n,
                           input int budget);
    int start;
    int k;
    start = pops;
    k = 0;
    while ((pops - start) < n && k < budget) begin
      step();
      k++;
    end
    compared++;
    if ((pops - start) < n) begin
      mismatched++;
      $display("FAIL %s: got %0d pops expected %0d",
               name, pops - start, n);
    end
  endtask

  // imem: gnt from gnt_en, in-order rvalid one cycle after gnt
  assign imem_gnt_i = gnt_en;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= '0;
    end else begin
      if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
      if (rsp_en && mq.size() > 0) begin
        imem_rvalid_i <= 1'b1;
        imem_rdata_i  <= mem_word(mq.pop_front());
      end else begin
        imem_rvalid_i <= 1'b0;
      end
    end
  end

  // monitor: every accepted instruction must be the next expected one
  always @(negedge clk) begin
    if (!rst && inst_valid_o && inst_ready_i) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_inst: got addr %h expected none",
                 inst_addr_o);
      end else begin
        mon_e = sb.pop_front();
        check("inst_addr", inst_addr_o, mon_e.addr);
        check("inst_data", inst_o, mon_e.inst);
        pops++;
      end
    end
  end

  initial begin
    int found;
    rst          = 1'b1;
    jump_en_i    = 1'b0;
    jump_addr_i  = '0;
    inst_ready_i = 1'b1;
    gnt_en       = 1'b1;
    rsp_en       = 1'b1;
    push_stream(32'h0);
    step(3);
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_valid", 32'(inst_valid_o), 32'h0);
    check("rst_inst", inst_o, 32'h0000_0013);
    check("rst_iaddr", inst_addr_o, 32'h0);

    // T1: first fetches and latency
    rst = 1'b0;
    #1;
    check("t1_c0_req", 32'(imem_req_o), 32'h1);
    check("t1_c0_addr", imem_addr_o, 32'h0);
    step();
    check("t1_c1_addr", imem_addr_o, 32'h4);
    check("t1_c1_valid", 32'(inst_valid_o), 32'h0);
    step();
    check("t1_c2_valid", 32'(inst_valid_o), 32'h1);
    check("t1_c2_iaddr", inst_addr_o, 32'h0);
    check("t1_c2_full_req", 32'(imem_req_o), 32'h0);
    wait_pops("t1_stream", 6, 20);

    // T2: decode stall fills the queue and holds output
    inst_ready_i = 1'b0;
    step(3);
    check("t2_req_full", 32'(imem_req_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(inst_valid_o), 32'h1);
      check("t2_hold_iaddr", inst_addr_o, sb[0].addr);
      check("t2_hold_inst", inst_o, sb[0].inst);
      step();
    end
    inst_ready_i = 1'b1;
    wait_pops("t2_resume", 6, 20);

    // T3: redirect with two responses outstanding
    rsp_en = 1'b0;
    step(6);
    check("t3_pend_req", 32'(imem_req_o), 32'h0);
    check("t3_pend_valid", 32'(inst_valid_o), 32'h0);
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h100;
    push_stream(32'h100);
    #1;
    check("t3_jmp_req", 32'(imem_req_o), 32'h0);
    check("t3_jmp_inst", inst_o, 32'h0000_0013);
    step();
    jump_en_i = 1'b0;
    rsp_en    = 1'b1;
    #1;
    check("t3_req_addr", imem_addr_o, 32'h100);
    check("t3_req", 32'(imem_req_o), 32'h1);
    wait_pops("t3_redirect", 4, 30);

    // T4: redirect in the same cycle as a response
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (imem_rvalid_i) found = 1;
    end
    check("t4_rvalid_seen", 32'(found), 32'h1);
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h100;
    push_stream(32'h100);
    #1;
    check("t4_jmp_valid", 32'(inst_valid_o), 32'h0);
    step();
    jump_en_i = 1'b0;
    wait_pops("t4_redirect", 4, 30);

    // T5: grant withheld for 10 cycles after a redirect
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h300;
    gnt_en      = 1'b0;
    push_stream(32'h300);
    step();
    jump_en_i = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("t5_addr", imem_addr_o, 32'h300);
      check("t5_req", 32'(imem_req_o), 32'h1);
      check("t5_valid", 32'(inst_valid_o), 32'h0);
      check("t5_inst", inst_o, 32'h0000_0013);
      check("t5_iaddr", inst_addr_o, 32'h0);
      step();
    end
    gnt_en = 1'b1;
    wait_pops("t5_resume", 4, 30);

`ifdef IF_MISALIGN_CHK_EN
    // T6: misaligned redirect blocks issue until an aligned one
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h102;
    sb.delete();
    step();
    jump_en_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t6_err", 32'(fetch_err_o), 32'h1);
      check("t6_req", 32'(imem_req_o), 32'h0);
      check("t6_valid", 32'(inst_valid_o), 32'h0);
      step();
    end
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h200;
    push_stream(32'h200);
    step();
    jump_en_i = 1'b0;
    #1;
    check("t6_err_clr", 32'(fetch_err_o), 32'h0);
    check("t6_addr", imem_addr_o, 32'h200);
    wait_pops("t6_resume", 4, 30);
`else
    // T6: low target bits are ignored without the checker
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h402;
    push_stream(32'h400);
    step();
    jump_en_i = 1'b0;
    #1;
    check("t6_align_addr", imem_addr_o, 32'h400);
    wait_pops("t6_align", 4, 30);
`endif

    // T7: PC wraps past the top of the address space
    jump_en_i   = 1'b1;
    jump_addr_i = 32'hFFFF_FFF8;
    push_stream(32'hFFFF_FFF8);
    step();
    jump_en_i = 1'b0;
    wait_pops("t7_wrap", 4, 30);

    // T8: reset in the middle of a stream
    rst = 1'b1;
    sb.delete();
    #1;
    check("t8_rst_req", 32'(imem_req_o), 32'h0);
    check("t8_rst_valid", 32'(inst_valid_o), 32'h0);
    step(2);
    push_stream(32'h0);
    rst = 1'b0;
    #1;
    check("t8_addr", imem_addr_o, 32'h0);
    wait_pops("t8_restart", 4, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
